// File: rtl/wb_pkg.sv
// Shared types and helpers for the writeback arbiter slice.
package wb_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_PIPE,
    SRC_MUL
  } wb_src_e;

  // r0 is hard-wired zero, so it never contributes to a pending mask.
  function automatic logic [31:0] rdOneHot(input logic [REG_W-1:0] r);
    return (r == '0) ? 32'd0 : (32'd1 << r);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Mul/div result buffer: in-order circular FIFO with squash-by-rd and invalid-head skip.
// Optional squash trace under WB_TRACE_EN.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [REG_W-1:0]        pushRd,
  input  logic [DATA_W-1:0]       pushData,
  input  logic                    pop,
  input  logic                    squashEn,
  input  logic [REG_W-1:0]        squashRd,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    headValid,
  output logic [REG_W-1:0]        headRd,
  output logic [DATA_W-1:0]       headData,
  output logic [31:0]             rdMask
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             dropHead;
  logic             doPop;

  assign headValid = mem[rdPtr].valid;
  assign headRd    = mem[rdPtr].rd;
  assign headData  = mem[rdPtr].data;

  // A squashed head is retired silently without using an output slot.
  assign dropHead = (count != '0) && !mem[rdPtr].valid;
  assign doPop    = (pop && headValid) || dropHead;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (squashEn && mem[i].valid && (mem[i].rd == squashRd)) mem[i].valid <= 1'b0;
      end
      if (doPop) begin
        mem[rdPtr].valid <= 1'b0;
        rdPtr            <= rdPtr + 1'b1;
      end
      // The push slot is always empty, so a same-cycle squash never hits it.
      if (push) begin
        mem[wrPtr] <= '{valid: 1'b1, rd: pushRd, data: pushData};
        wrPtr      <= wrPtr + 1'b1;
      end
      count <= count + CNT_W'(push) - CNT_W'(doPop);
    end
  end

  always_comb begin
    rdMask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem[i].valid) rdMask = rdMask | rdOneHot(mem[i].rd);
    end
  end

`ifdef WB_TRACE_EN
  always_ff @(posedge clk) begin
    if (rst_n && squashEn) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (mem[i].valid && (mem[i].rd == squashRd))
          $write("[wb_fifo] squash r%0d entry %0d\n", squashRd, i);
      end
    end
  end
`else
`endif

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: pipeline has priority, mul/div results buffered, starvation stall.
// Define WB_TRACE_EN for a $write trace of writes, squashes and stall assertions.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pWr,
  input  logic [4:0]  pRd,
  input  logic [31:0] pData,
  input  logic        mValid,
  input  logic [4:0]  mRd,
  input  logic [31:0] mData,
  output logic        mReady,
  output logic        stall,
  output logic [4:0]  rd,
  output logic [31:0] wData,
  output logic        regWr,
  output logic [31:0] pendMask
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int AGE_W = $clog2(STARVE_MAX) + 1;

  logic [CNT_W-1:0]  count;
  logic              headValid;
  logic [REG_W-1:0]  headRd;
  logic [DATA_W-1:0] headData;
  logic [31:0]       fifoMask;
  logic              fifoPush;
  wb_src_e           src;
  logic [AGE_W-1:0]  headAge;
  logic [AGE_W-1:0]  ageNext;
  logic              stallNext;

  // r0 results still complete the handshake but are never buffered.
  assign mReady   = (count < CNT_W'(DEPTH));
  assign fifoPush = mValid && mReady && (mRd != '0);

  always_comb begin
    src = SRC_NONE;
    if (!stall && pWr && (pRd != '0)) src = SRC_PIPE;
    else if (headValid)               src = SRC_MUL;
  end

  // Age saturates so a long-starved head cannot wrap back below the threshold.
  always_comb begin
    ageNext = '0;
    if (headValid && (src != SRC_MUL))
      ageNext = (headAge == '1) ? headAge : headAge + 1'b1;
  end

  assign stallNext = (int'(ageNext) >= STARVE_MAX - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      headAge <= '0;
      stall   <= 1'b0;
      regWr   <= 1'b0;
      rd      <= '0;
      wData   <= '0;
    end else begin
      headAge <= ageNext;
      stall   <= stallNext;
      regWr   <= (src != SRC_NONE);
      case (src)
        SRC_PIPE: begin
          rd    <= pRd;
          wData <= pData;
        end
        SRC_MUL: begin
          rd    <= headRd;
          wData <= headData;
        end
        default: ;
      endcase
    end
  end

  wb_fifo #(
    .DEPTH(DEPTH)
  ) uFifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifoPush),
    .pushRd    (mRd),
    .pushData  (mData),
    .pop       (src == SRC_MUL),
    .squashEn  (src == SRC_PIPE),
    .squashRd  (pRd),
    .count     (count),
    .headValid (headValid),
    .headRd    (headRd),
    .headData  (headData),
    .rdMask    (fifoMask)
  );

  assign pendMask = fifoMask | (regWr ? rdOneHot(rd) : 32'd0);

  always_ff @(posedge clk) begin
    if (rst_n && stall && pWr)
      $warning("[wb_arbiter] protocol violation: pWr to r%0d during stall, write dropped", pRd);
  end

`ifdef WB_TRACE_EN
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (src == SRC_PIPE) $write("[wb_arbiter] write P r%0d = %h\n", pRd, pData);
      if (src == SRC_MUL)  $write("[wb_arbiter] write M r%0d = %h\n", headRd, headData);
      if (stallNext && !stall) $write("[wb_arbiter] stall asserted\n");
    end
  end
`else
`endif

endmodule
